fifo_write_ctrl: RTL and testbench

- Write-side controller of the synchronous FIFO; counterpart to the read-side block.
- Accepts producer write requests and owns the write pointer.
- Derives full, almost-full, occupancy and write-error flags from its own pointer and the read-side pointer.
- Drives the FIFO memory write port through one register stage.

---
 rtl/fifo_write_ctrl_if.sv | 36 +++
 rtl/fifo_write_ctrl.sv | 83 ++++++++
 tb/tb_fifo_write_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_write_ctrl_if : producer/read-pointer/memory bus of write ctrl |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fifo_write_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              err_clr;
  logic [AW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic              fifo_wr_err;
  logic [AW:0]       wr_count;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output wr_en, wr_data, err_clr, rd_ptr,
    input  fifo_full, fifo_almost_full, fifo_wr_err, wr_count,
    input  mem_wr_en, mem_waddr, mem_wdata
  );

  modport slave (
    input  wr_en, wr_data, err_clr, rd_ptr,
    output fifo_full, fifo_almost_full, fifo_wr_err, wr_count,
    output mem_wr_en, mem_waddr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fifo_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_write_ctrl : write-side controller of the synchronous FIFO    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fifo_write_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic            CLK,
  input  logic            nRST,
  fifo_write_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_af    = (AW+1)'(AF_THRESH);

  logic [AW:0]       r_wr_ptr;
  logic              r_full;
  logic              r_almost_full;
  logic              r_wr_err;
  logic [AW:0]       r_wr_count;
  logic              r_mem_wr_en;
  logic [AW-1:0]     r_mem_waddr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [AW:0]       w_occ;
  logic              w_full_now;
  logic              w_accept;
  logic              w_overflow;
  logic [AW:0]       w_wr_ptr_next;
  logic [AW:0]       w_occ_next;

  // Acceptance uses the live read pointer; the flags lag it by one cycle.
  always_comb begin
    w_occ         = r_wr_ptr - bus.rd_ptr;
    w_full_now    = (w_occ == c_depth);
    w_accept      = bus.wr_en & ~w_full_now;
    w_overflow    = bus.wr_en & w_full_now;
    w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, w_accept};
    w_occ_next    = w_wr_ptr_next - bus.rd_ptr;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wr_err      <= 1'b0;
      r_wr_count    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_waddr   <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_next;
      r_wr_count    <= w_occ_next;
      r_full        <= (w_occ_next == c_depth);
      r_almost_full <= (w_occ_next >= c_af);
      r_mem_wr_en   <= w_accept;
      if (w_accept) begin
        r_mem_waddr <= r_wr_ptr[AW-1:0];
        r_mem_wdata <= bus.wr_data;
      end
      // A new overflow outranks a simultaneous clear.
      if (w_overflow) begin
        r_wr_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_wr_err <= 1'b0;
      end
    end
  end

  assign bus.fifo_full        = r_full;
  assign bus.fifo_almost_full = r_almost_full;
  assign bus.fifo_wr_err      = r_wr_err;
  assign bus.wr_count         = r_wr_count;
  assign bus.mem_wr_en        = r_mem_wr_en;
  assign bus.mem_waddr        = r_mem_waddr;
  assign bus.mem_wdata        = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_write_ctrl : randomized bench with count-based FIFO model  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fifo_write_ctrl;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;
  localparam int AW        = 4;

  logic CLK;
  logic nRST;

  fifo_write_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_write_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;
  bit ph6      = 0;
  int n6       = 0;
  int last6    = -1;
  int rd_total = 0;

  // Model: total words written vs total words read, as plain integers.
  int m_wr     = 0;
  bit e_wr_en  = 0;
  int e_waddr  = 0;
  int e_wdata  = 0;
  int e_count  = 0;
  bit e_full   = 0;
  bit e_af     = 0;
  bit e_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_wr <= 0; e_wr_en <= 0; e_waddr <= 0; e_wdata <= 0;
      e_count <= 0; e_full <= 0; e_af <= 0; e_err <= 0;
    end else if (chk_on) begin
      int occ, nw;
      bit acc, ovf;
      occ = m_wr - rd_total;
      chk("occ_in_range", int'(occ >= 0 && occ <= DEPTH), 1);
      acc = bus.wr_en && (occ < DEPTH);
      ovf = bus.wr_en && (occ >= DEPTH);
      nw  = m_wr + int'(acc);
      m_wr    <= nw;
      e_wr_en <= acc;
      if (acc) begin
        e_waddr <= m_wr % DEPTH;
        e_wdata <= int'(bus.wr_data);
      end
      e_count <= nw - rd_total;
      e_full  <= (nw - rd_total) == DEPTH;
      e_af    <= (nw - rd_total) >= AF_THRESH;
      if (ovf) e_err <= 1;
      else if (bus.err_clr) e_err <= 0;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("mem_wr_en", int'(bus.mem_wr_en), int'(e_wr_en));
      chk("mem_waddr", int'(bus.mem_waddr), e_waddr);
      chk("mem_wdata", int'(bus.mem_wdata), e_wdata);
      chk("wr_count", int'(bus.wr_count), e_count);
      chk("fifo_full", int'(bus.fifo_full), int'(e_full));
      chk("fifo_almost_full", int'(bus.fifo_almost_full), int'(e_af));
      chk("fifo_wr_err", int'(bus.fifo_wr_err), int'(e_err));
      if (ph6 && bus.mem_wr_en) begin
        n6++;
        last6 = int'(bus.mem_waddr);
      end
    end
  end

  task automatic step(input bit we, input logic [7:0] wd, input bit ec, input bit rinc);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.err_clr = ec;
    if (rinc) rd_total++;
    bus.rd_ptr  = (AW+1)'(rd_total);
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.wr_en = 0; bus.err_clr = 0; bus.wr_data = '0;
    rd_total = 0; bus.rd_ptr = '0;
    @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    bus.wr_en = 0; bus.wr_data = '0; bus.err_clr = 0; bus.rd_ptr = '0;
    #3;
    // Reset while a write is requested: nothing may happen until release.
    nRST = 1'b0;
    bus.wr_en = 1;
    #1 chk_on = 1;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_mem_wr_en", int'(bus.mem_wr_en), 0);
    chk("rst_wr_count", int'(bus.wr_count), 0);
    chk("rst_flags", int'({bus.fifo_full, bus.fifo_almost_full, bus.fifo_wr_err}), 0);
    nRST = 1'b1;
    #1 chk("release_no_strobe", int'(bus.mem_wr_en), 0);
    @(posedge CLK);
    #2;
    chk("release_strobe", int'(bus.mem_wr_en), 1);
    chk("release_count", int'(bus.wr_count), 1);
    // Asynchronous reset drops a pending strobe immediately.
    nRST = 1'b0;
    bus.wr_en = 0;
    #1;
    chk("async_rst_strobe", int'(bus.mem_wr_en), 0);
    chk("async_rst_count", int'(bus.wr_count), 0);
    @(posedge CLK);
    #2;
    nRST = 1'b1;

    // Single write.
    step(1, 8'hA5, 0, 0);
    chk("single_wr_en", int'(bus.mem_wr_en), 1);
    chk("single_waddr", int'(bus.mem_waddr), 0);
    chk("single_wdata", int'(bus.mem_wdata), 8'hA5);
    chk("single_count", int'(bus.wr_count), 1);
    chk("single_flags", int'({bus.fifo_full, bus.fifo_almost_full, bus.fifo_wr_err}), 0);
    step(0, 8'h00, 0, 0);
    chk("idle_wr_en", int'(bus.mem_wr_en), 0);
    chk("idle_wdata_hold", int'(bus.mem_wdata), 8'hA5);

    // Fill to full, then overflow.
    for (int n = 2; n <= DEPTH; n++) begin
      step(1, 8'(n), 0, 0);
      chk("fill_af", int'(bus.fifo_almost_full), int'(n >= 12));
      chk("fill_full", int'(bus.fifo_full), int'(n == 16));
    end
    chk("full_count", int'(bus.wr_count), 16);
    step(1, 8'hEE, 0, 0);
    chk("ovf_wr_en", int'(bus.mem_wr_en), 0);
    chk("ovf_err", int'(bus.fifo_wr_err), 1);
    chk("ovf_count", int'(bus.wr_count), 16);
    chk("ovf_waddr_hold", int'(bus.mem_waddr), 15);

    // Read lands after this edge: write still rejected; next cycle accepted.
    step(1, 8'h11, 0, 0);
    chk("full_rd_reject", int'(bus.mem_wr_en), 0);
    step(1, 8'h22, 0, 1);
    chk("wrap_wr_en", int'(bus.mem_wr_en), 1);
    chk("wrap_waddr", int'(bus.mem_waddr), 0);
    chk("wrap_wdata", int'(bus.mem_wdata), 8'h22);
    chk("wrap_count", int'(bus.wr_count), 16);

    // Sticky error: clear, then clear colliding with overflow.
    step(0, 8'h00, 1, 0);
    chk("err_cleared", int'(bus.fifo_wr_err), 0);
    step(1, 8'h33, 1, 0);
    chk("err_set_wins", int'(bus.fifo_wr_err), 1);
    chk("err_set_no_wr", int'(bus.mem_wr_en), 0);

    // Random traffic, reads never overtaking writes.
    for (int i = 0; i < 300; i++) begin
      int occ;
      bit we, ec, rinc;
      occ  = m_wr - rd_total;
      we   = ($urandom % 4) != 0;
      ec   = ($urandom % 8) == 0;
      rinc = (occ > 0) && (($urandom % 3) == 0);
      step(we, 8'($urandom), ec, rinc);
    end

    // 40 writes with occupancy held within 2..5.
    do_reset();
    ph6 = 1;
    for (int g = 0; g < 500 && m_wr < 40; g++) begin
      int occ, r;
      bit we, rinc;
      occ = m_wr - rd_total;
      r   = int'($urandom % 4);
      if (occ <= 2) begin
        we = 1; rinc = (occ == 2) && (r == 0);
      end else if (occ >= 5) begin
        we = 0; rinc = 1;
      end else begin
        we = r[0]; rinc = r[1];
      end
      step(we, 8'($urandom), 0, rinc);
    end
    step(0, 8'h00, 0, 0);
    ph6 = 0;
    chk("ph6_writes", n6, 40);
    chk("ph6_last_waddr", last6, 7);
    chk("ph6_no_err", int'(bus.fifo_wr_err), 0);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
